add_sub_accumulator: RTL and testbench
======================================

ADD_SUB_ACCUMULATOR -- requirements
Module: add_sub_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the accumulator and operand width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: a command is present on op/operand.
REQ-005 Port in_ready, output, 1 bit: the block can accept a command.
REQ-006 Port op, input, 2 bits: command code; 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-007 Port operand, input, WIDTH bits: the B operand.
REQ-008 Port out_valid, output, 1 bit: a result is presented.
REQ-009 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 Port acc, output, WIDTH bits: the accumulator register.
REQ-011 Port carry, output, 1 bit: adder carry-out of the last command.
REQ-012 Port zero, output, 1 bit: acc equals 0.
REQ-013 Port overflow, output, 1 bit: two's-complement overflow of the last command.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-015 in_ready SHALL be 1 only in IDLE with rst_n=1, and out_valid SHALL be 1 only in RESP.
REQ-016 A command is accepted on an edge where in_valid&in_ready=1; op and operand are captured, and IDLE->EXEC.
REQ-017 EXEC SHALL last exactly one cycle; on its closing edge acc/carry/overflow/zero update and EXEC->RESP, so out_valid rises 2 edges after acceptance.
REQ-018 RESP->IDLE on an edge with out_ready=1; otherwise out_valid and all result outputs SHALL hold unchanged.
REQ-019 in_valid SHALL be ignored outside IDLE; no command is queued or lost-tracked.
REQ-020 Arithmetic SHALL use the adder/subtractor form: with m=op[1]&~op[0], {cout,sum} = acc + (operand XOR {WIDTH{m}}) + m, computed in WIDTH+1 bits.
REQ-021 ADD SHALL set acc=sum[WIDTH-1:0] and carry=cout, with wrap-around modulo 2^WIDTH.
REQ-022 SUB SHALL set acc=sum[WIDTH-1:0] and carry=cout, where carry=1 means no borrow (acc>=operand unsigned).
REQ-023 For ADD, overflow SHALL be 1 iff the MSBs of acc and operand are equal and the MSB of the result differs from them; for SUB, overflow SHALL be 1 iff those MSBs differ and the result MSB differs from the old acc MSB.
REQ-024 LOAD SHALL set acc=operand; CLR SHALL set acc=0; both SHALL set carry=0 and overflow=0.
REQ-025 zero SHALL be 1 iff the updated acc is all zeros, and SHALL be valid whenever acc is.
REQ-026 acc SHALL change only on the EXEC->RESP edge or on reset.

Reset
REQ-027 On any edge with rst_n=0, in any state including EXEC or RESP, the block SHALL go to IDLE with acc=0, carry=0, overflow=0, zero=1 and out_valid=0; any in-flight command is discarded without a response.
REQ-028 While rst_n=0, in_ready SHALL be 0.
REQ-029 The first command SHALL be accepted no earlier than the first edge with rst_n=1.

Verification
REQ-030 Reset, then LOAD 0101 -> out_valid=1 two edges after acceptance; acc=0101, carry=0, zero=0, overflow=0.
REQ-031 LOAD 1000, then ADD 1000 -> acc=0000, carry=1, zero=1, overflow=1; ADD 1111 then gives acc=1111, carry=0.
REQ-032 LOAD 0111, SUB 0111 -> acc=0000, carry=1, zero=1, overflow=0; then LOAD 0011, SUB 0101 -> acc=1110, carry=0, overflow=0.
REQ-033 LOAD 0111, ADD 0001 -> acc=1000, carry=0, overflow=1; then SUB 0001 -> acc=0111, carry=1, overflow=1.
REQ-034 Hold out_ready=0 for 5 cycles in RESP while driving in_valid=1 -> out_valid, acc and flags stay constant, in_ready=0, and the extra command is not executed; with out_ready=1, IDLE follows on the next edge.
REQ-035 Drop rst_n to 0 for one edge during EXEC of ADD 0011 (acc=0100) -> no out_valid, acc=0000, zero=1; in_ready=1 on the first cycle after rst_n returns to 1.

Source files
------------

// File: rtl/add_sub_accumulator.sv
// Accumulator with a LOAD/ADD/SUB/CLR command interface and a one-deep response.
// Each command passes through IDLE -> EXEC -> RESP. The result and its flags are held
// in RESP until the consumer takes them.
module add_sub_accumulator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpAdd  = 2'b01;
    localparam logic [1:0] OpSub  = 2'b10;
    localparam logic [1:0] OpClr  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Shared adder/subtractor datapath signals
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic             a_msb, b_msb, r_msb;
    logic             add_ovf, sub_ovf;
    logic             accept;

    // Handshake outputs; in_ready is gated by rst_n so nothing is offered during reset
    always_comb begin
        in_ready  = (state_q == StIdle) && rst_n;
        out_valid = (state_q == StResp);
        accept    = in_valid && in_ready;
    end

    // Adder/subtractor: SUB inverts B and injects a carry-in of 1
    always_comb begin
        sub_mode = op_q[1] & ~op_q[0];
        b_eff    = operand_q ^ {WIDTH{sub_mode}};
        sum_full = {1'b0, acc_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
        a_msb    = acc_q[WIDTH-1];
        b_msb    = operand_q[WIDTH-1];
        r_msb    = sum_full[WIDTH-1];
        add_ovf  = (a_msb == b_msb) && (r_msb != a_msb);
        sub_ovf  = (a_msb != b_msb) && (r_msb != a_msb);
    end

    // Next-state and command-capture logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = op;
                    operand_d = operand;
                    state_d   = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Result update; only the EXEC closing edge modifies acc and the flags
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (state_q == StExec) begin
            unique case (op_q)
                OpLoad: begin
                    acc_d   = operand_q;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OpAdd: begin
                    acc_d   = sum_full[WIDTH-1:0];
                    carry_d = sum_full[WIDTH];
                    ovf_d   = add_ovf;
                end
                OpSub: begin
                    acc_d   = sum_full[WIDTH-1:0];
                    carry_d = sum_full[WIDTH];
                    ovf_d   = sub_ovf;
                end
                OpClr: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
            zero_d = (acc_d == '0);
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpLoad;
            operand_q <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
        end
    end

    assign acc      = acc_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Directed bench for add_sub_accumulator with WIDTH=4 and hand-computed expectations.
module tb_add_sub_accumulator;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             zero;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpAdd  = 2'b01;
    localparam logic [1:0] OpSub  = 2'b10;

    add_sub_accumulator #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand  (operand),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc      (acc),
        .carry    (carry),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, check its two-edge latency, leave the block in RESP
    task automatic issue(input string tag, input logic [1:0] c, input logic [WIDTH-1:0] b);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = c;
        operand  = b;
        tick();
        in_valid = 1'b0;
        check({tag, ".exec_no_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic result(input string tag, input logic [WIDTH-1:0] e_acc, input logic e_c,
                          input logic e_z, input logic e_o);
        check({tag, ".acc"}, 32'(acc), 32'(e_acc));
        check({tag, ".carry"}, 32'(carry), 32'(e_c));
        check({tag, ".zero"}, 32'(zero), 32'(e_z));
        check({tag, ".overflow"}, 32'(overflow), 32'(e_o));
    endtask

    // Consume the response and return to IDLE
    task automatic release_resp(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".idle_no_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = OpLoad;
        operand   = 4'b1111;
        out_ready = 1'b0;

        // Reset with a command pending; it must not be taken
        tick();
        check("rst.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        result("rst", 4'b0000, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst.release_ready", 32'(in_ready), 32'd1);

        // Basic LOAD
        issue("load5", OpLoad, 4'b0101);
        result("load5", 4'b0101, 1'b0, 1'b0, 1'b0);
        release_resp("load5");

        // Signed overflow with carry and zero result, then plain ADD
        issue("load8", OpLoad, 4'b1000);
        release_resp("load8");
        issue("add8", OpAdd, 4'b1000);
        result("add8", 4'b0000, 1'b1, 1'b1, 1'b1);
        release_resp("add8");
        issue("addf", OpAdd, 4'b1111);
        result("addf", 4'b1111, 1'b0, 1'b0, 1'b0);
        release_resp("addf");

        // SUB to zero (no borrow), then SUB with borrow
        issue("load7", OpLoad, 4'b0111);
        release_resp("load7");
        issue("sub7", OpSub, 4'b0111);
        result("sub7", 4'b0000, 1'b1, 1'b1, 1'b0);
        release_resp("sub7");
        issue("load3", OpLoad, 4'b0011);
        release_resp("load3");
        issue("sub5", OpSub, 4'b0101);
        result("sub5", 4'b1110, 1'b0, 1'b0, 1'b0);
        release_resp("sub5");

        // Positive overflow on ADD, negative overflow on SUB
        issue("load7b", OpLoad, 4'b0111);
        release_resp("load7b");
        issue("add1", OpAdd, 4'b0001);
        result("add1", 4'b1000, 1'b0, 1'b0, 1'b1);
        release_resp("add1");
        issue("sub1", OpSub, 4'b0001);
        result("sub1", 4'b0111, 1'b1, 1'b0, 1'b1);

        // Back-pressure in RESP with a competing command on the input
        in_valid = 1'b1;
        op       = OpAdd;
        operand  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold.out_valid", 32'(out_valid), 32'd1);
            check("hold.in_ready", 32'(in_ready), 32'd0);
            result("hold", 4'b0111, 1'b1, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        release_resp("hold");
        tick();
        check("hold.not_executed_acc", 32'(acc), 32'h7);
        check("hold.not_executed_valid", 32'(out_valid), 32'd0);

        // Reset landing on the EXEC closing edge discards the command
        issue("load4", OpLoad, 4'b0100);
        release_resp("load4");
        in_valid = 1'b1;
        op       = OpAdd;
        operand  = 4'b0011;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("rstx.out_valid", 32'(out_valid), 32'd0);
        check("rstx.in_ready", 32'(in_ready), 32'd0);
        result("rstx", 4'b0000, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rstx.ready_after", 32'(in_ready), 32'd1);
        tick();
        check("rstx.no_late_valid", 32'(out_valid), 32'd0);
        check("rstx.acc_after", 32'(acc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
